// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a registered-output UART transmitter (8N1 frames, LSB first).
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_fifo #(
   parameter int unsigned CLK_DIV = 16,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wvalid,
   input  logic [7:0]       wdata,
   output logic             wready,
   output logic             tx,
   output logic             busy,
   output logic [FIFO_AW:0] level
);

   localparam int unsigned Depth = 2 ** FIFO_AW;
   localparam int unsigned BaudW = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
   typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

   // FIFO storage and pointers; pointers carry one extra bit for full/empty.
   logic [7:0]       mem_q [Depth];
   logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
   logic             push, pop, empty, full;
   logic [7:0]       pop_data;

   assign level    = wr_ptr_q - rd_ptr_q;
   assign full     = (level == (FIFO_AW + 1)'(Depth));
   assign empty    = (level == '0);
   assign wready   = ~full;
   assign push     = wvalid & wready;
   assign pop_data = mem_q[rd_ptr_q[FIFO_AW-1:0]];

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Transmitter
   state_e           state_q, state_d;
   logic [BaudW-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       sh_q, sh_d;
   logic             tx_q, tx_d;
   logic             bit_end;
`ifdef UART_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   assign bit_end = (baud_q == BaudW'(CLK_DIV - 1));

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif

      if (state_q != StIdle) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = 3'd0;
            end
         end
         StData: begin
            if (bit_end) begin
               sh_d  = {1'b0, sh_q[7:1]};
               bit_d = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) state_d = StStop;
         end
`endif
         StStop: begin
            if (bit_end) begin
               // Pop straight into the next start bit so frames run back to back.
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = StStart;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (pop) begin
         sh_d = pop_data;
`ifdef UART_TX_PARITY_EN
         par_d = ^pop_data;
`endif
      end

      // tx is computed from the next state so the line register changes on bit boundaries.
      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = par_q;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign tx   = tx_q;
   assign busy = (state_q != StIdle) | ~empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CLK_DIV=4, FIFO_AW=4.
// Outputs sampled on the falling clock edge; inputs driven there too.
module tb_uart_tx_fifo;

   localparam int unsigned CD = 4;
   localparam int unsigned AW = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned NBITS = 11;
`else
   localparam int unsigned NBITS = 10;
`endif
   localparam int unsigned FR = NBITS * CD;

   logic          clock  = 1'b0;
   logic          reset  = 1'b0;
   logic          wvalid = 1'b0;
   logic [7:0]    wdata  = 8'h00;
   logic          wready;
   logic          tx;
   logic          busy;
   logic [AW:0]   level;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_fifo #(
      .CLK_DIV (CD),
      .FIFO_AW (AW)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .wvalid (wvalid),
      .wdata  (wdata),
      .wready (wready),
      .tx     (tx),
      .busy   (busy),
      .level  (level)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits for the first start-bit sample; a timeout counts as a failed check.
   task automatic wait_start(input string tag);
      int i = 0;
      @(negedge clock);
      while (tx !== 1'b0 && i < 200) begin
         @(negedge clock);
         i++;
      end
      if (tx !== 1'b0) check(tag, 32'(tx), 32'd0);
   endtask

   // The current sample is the first start-bit cycle; collects one full frame.
   task automatic capture(output logic [7:0] b, output logic par, output logic good);
      logic s [FR];
      for (int i = 0; i < int'(FR); i++) begin
         if (i != 0) @(negedge clock);
         s[i] = tx;
      end
      good = (s[0] === 1'b0) && (s[FR-1] === 1'b1);
      for (int k = 0; k < int'(NBITS); k++)
         for (int j = 1; j < int'(CD); j++)
            if (s[k*CD+j] !== s[k*CD]) good = 1'b0;
      for (int k = 0; k < 8; k++) b[k] = s[(k+1)*CD];
      par = s[9*CD];
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] b;
      logic       par, good;

      repeat (3) @(negedge clock);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_wready", 32'(wready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      reset = 1'b1;

      // Single byte 0x55
      @(negedge clock); wvalid = 1'b1; wdata = 8'h55;
      @(negedge clock); wvalid = 1'b0;
      check("t1_level", 32'(level), 32'd1);
      check("t1_tx_idle", 32'(tx), 32'd1);
      check("t1_busy", 32'(busy), 32'd1);
      @(negedge clock);
      check("t1_start", 32'(tx), 32'd0);
      capture(b, par, good);
      check("t1_byte", 32'(b), 32'h55);
      check("t1_frame", 32'(good), 32'd1);
      check("t1_busy_last", 32'(busy), 32'd1);
      @(negedge clock);
      check("t1_busy_drop", 32'(busy), 32'd0);
      check("t1_tx_high", 32'(tx), 32'd1);

      // Two bytes on consecutive cycles
      @(negedge clock); wvalid = 1'b1; wdata = 8'hA5;
      @(negedge clock); wdata = 8'h3C;
      @(negedge clock); wvalid = 1'b0;
      check("t2_level", 32'(level), 32'd1);
      check("t2_start", 32'(tx), 32'd0);
      capture(b, par, good);
      check("t2_byte0", 32'(b), 32'hA5);
      check("t2_frame0", 32'(good), 32'd1);
      @(negedge clock);
      check("t2_no_gap", 32'(tx), 32'd0);
      capture(b, par, good);
      check("t2_byte1", 32'(b), 32'h3C);
      check("t2_frame1", 32'(good), 32'd1);
      @(negedge clock);
      check("t2_busy_drop", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
      @(negedge clock); wvalid = 1'b1; wdata = 8'h07;
      @(negedge clock); wvalid = 1'b0;
      wait_start("tp_start0");
      capture(b, par, good);
      check("tp_byte0", 32'(b), 32'h07);
      check("tp_par0", 32'(par), 32'd1);
      check("tp_frame0", 32'(good), 32'd1);
      @(negedge clock);
      check("tp_busy_drop", 32'(busy), 32'd0);
      @(negedge clock); wvalid = 1'b1; wdata = 8'h03;
      @(negedge clock); wvalid = 1'b0;
      wait_start("tp_start1");
      capture(b, par, good);
      check("tp_byte1", 32'(b), 32'h03);
      check("tp_par1", 32'(par), 32'd0);
`endif

      // Stream 0x00..0x12 with wvalid held: fills the FIFO and pushes against full
      @(negedge clock);
      fork
         begin : pusher
            int          idx = 0;
            logic        seen_full = 1'b0;
            logic        seen_drop = 1'b0;
            logic        acc;
            logic [AW:0] lv;
            wdata  = 8'h00;
            wvalid = 1'b1;
            for (int c = 0; c < 3000 && idx < 19; c++) begin
               acc = wready;
               lv  = level;
               @(negedge clock);
               if (acc) idx++;
               wdata = 8'(idx);
               if (lv == 5'd16 && !seen_full) begin
                  seen_full = 1'b1;
                  check("t3_full_wready", 32'(acc), 32'd0);
                  check("t3_full_idx", 32'(idx), 32'd17);
               end
               if (lv == 5'd16 && level != 5'd16 && !seen_drop) begin
                  seen_drop = 1'b1;
                  check("t5_drop_level", 32'(level), 32'd15);
                  check("t5_drop_idx", 32'(idx), 32'd17);
               end
            end
            wvalid = 1'b0;
            check("t3_all_pushed", 32'(idx), 32'd19);
            check("t3_saw_full", 32'(seen_full), 32'd1);
            check("t5_saw_drop", 32'(seen_drop), 32'd1);
         end
         begin : receiver
            logic [7:0] rb;
            logic       rp, rg;
            for (int k = 0; k < 19; k++) begin
               wait_start("t3_start");
               capture(rb, rp, rg);
               check("t3_order", 32'(rb), 32'(k));
               check("t3_frame", 32'(rg), 32'd1);
            end
         end
      join
      @(negedge clock);
      check("t3_busy_drop", 32'(busy), 32'd0);
      check("t3_level_empty", 32'(level), 32'd0);

      // Reset in the middle of data bit 3 of 0xF0, with 0x12 queued behind it
      @(negedge clock); wvalid = 1'b1; wdata = 8'hF0;
      @(negedge clock); wdata = 8'h12;
      @(negedge clock); wvalid = 1'b0;
      check("t4_start", 32'(tx), 32'd0);
      repeat (4 * CD + 1) @(negedge clock);
      check("t4_bit3", 32'(tx), 32'd0);
      check("t4_level_pre", 32'(level), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("t4_rst_tx", 32'(tx), 32'd1);
      check("t4_rst_level", 32'(level), 32'd0);
      check("t4_rst_wready", 32'(wready), 32'd1);
      check("t4_rst_busy", 32'(busy), 32'd0);
      @(negedge clock);
      @(negedge clock); reset = 1'b1;
      @(negedge clock); wvalid = 1'b1; wdata = 8'hFF;
      @(negedge clock); wvalid = 1'b0;
      wait_start("t4_restart");
      capture(b, par, good);
      check("t4_byte", 32'(b), 32'hFF);
      check("t4_frame", 32'(good), 32'd1);
      @(negedge clock);
      check("t4_busy_drop", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Serial transmit back-end for the simulation top's console output. It consumes the byte stream produced by the AXI write path on accepted writes to the serial port. Each byte is buffered in a FIFO and serialised as 8N1 UART frames onto the top-level uart_tx pin. It sits directly downstream of the AXI slave write channel, replacing DPI printing for pin-accurate output.

Parameters:
CLK_DIV, 16, clock cycles per UART bit; legal range is 2 or more.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.

Ports:
clock  input  1  single clock; all state on posedge.
reset  input  1  asynchronous, active-low; 0 = reset asserted.
wvalid  input  1  byte offered; the top drives this from the write handshake qualified by the serial-port address.
wdata  input  8  byte to transmit; the top drives this from the low byte of the AXI write data.
wready  output  1  FIFO can accept a byte.
tx  output  1  serial line; idles high.
busy  output  1  a frame is in progress, or the FIFO is non-empty.
level  output  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low.
- Reset values, applied asynchronously while reset=0:
  - tx=1, wready=1, busy=0, level=0.
  - FSM=IDLE, baud counter=0, bit counter=0.
  - FIFO pointers=0. FIFO contents are not reset.
- FIFO:
  - A push occurs when wvalid & wready.
  - wready = !full. It is registered from occupancy, so a push and a pop in the same cycle while full does not accept the push.
  - A push and a pop in the same cycle when neither full nor empty leaves level unchanged.
  - A write while wready=0 is not accepted. The producer is responsible for holding or dropping it.
  - Pointers wrap modulo 2**FIFO_AW. Full/empty are derived from an (FIFO_AW+1)-bit pointer difference.
- FSM states: IDLE, START, DATA, STOP.
  - Baud counter counts 0..CLK_DIV-1. bit_end = (count == CLK_DIV-1).
  - IDLE: tx=1. If the FIFO is non-empty, pop into shift register sh[7:0] and go to START next cycle.
  - START: tx=0 for CLK_DIV cycles. On bit_end, go to DATA with bit counter=0.
  - DATA: tx=sh[0], LSB first. On bit_end, shift right and increment the bit counter. After bit 7's bit_end, go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. On bit_end: if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- tx is driven from a register, so it is glitch-free.
- Latency: a push in cycle N makes level=1 in N+1. The IDLE pop happens in N+1, and tx falls at the clock edge ending N+1.
- Frame length is exactly 10*CLK_DIV cycles. Back-to-back frames follow each other with no gap.
- A push during an active frame never disturbs the frame in flight.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The partial frame and the FIFO contents are abandoned.
- busy = (state != IDLE) | (level != 0).

Optional Feature:
Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted between DATA and STOP. It drives tx = XOR of the 8 data bits (even parity) for CLK_DIV cycles. Frame length becomes 11*CLK_DIV.
- When undefined: there is no PARITY state, frames are 8N1 at 10*CLK_DIV, and the parity logic is not present.

Test Plan:
- CLK_DIV=4: push 0x55 once.
  -> tx low for 4 cycles starting 1 cycle after the push.
  -> Data bits 1,0,1,0,1,0,1,0 (LSB first), 4 cycles each, then high for 4 cycles.
  -> busy drops after 40 cycles.
- CLK_DIV=4: push 0xA5 then 0x3C on consecutive cycles.
  -> level peaks at 1 or 2.
  -> Two frames totalling 80 cycles, the second start bit immediately after the first stop bit.
  -> The sampled bytes decode as 0xA5, 0x3C.
- Hold wvalid with 17 bytes 0x00..0x10 while tx is stalled by a long CLK_DIV=1000.
  -> level saturates at 16 (one byte is already in flight) and wready=0.
  -> Pushes are accepted only as frames complete.
  -> The output order is 0x00..0x10 with no loss.
- Assert reset=0 in the middle of DATA bit 3.
  -> tx=1 within the same cycle, level=0, wready=1.
  -> After release, a new push of 0xFF transmits a clean frame.
- Push while full in the same cycle as the STOP-end pop.
  -> The push is not accepted (wready=0 that cycle).
  -> level goes 16 -> 15.
- With UART_TX_PARITY_EN: push 0x07.
  -> The parity bit is 1, and the frame is 44 cycles at CLK_DIV=4.
  -> Push 0x03 -> the parity bit is 0.
